// File: rtl/latch_wr_sched_if.sv
// Requester / latch-bank signal bundle for latch_wr_sched.
// master = requester + bank side, slave = scheduler.
interface latch_wr_sched_if #(
    parameter int NREQ = 4,
    parameter int NENT = 8,
    parameter int DW   = 8,
    parameter int AW   = $clog2(NENT),
    parameter int IW   = $clog2(NREQ)
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic               clr_req;
    logic [NENT-1:0]    lat_en;
    logic               lat_clr;
    logic [DW-1:0]      lat_d;
    logic               busy;
    logic               done;
    logic [IW-1:0]      done_id;
    logic               done_err;

    modport master (
        output req_valid, req_addr, req_data, clr_req,
        input  req_ready, lat_en, lat_clr, lat_d, busy, done, done_id, done_err
    );

    modport slave (
        input  req_valid, req_addr, req_data, clr_req,
        output req_ready, lat_en, lat_clr, lat_d, busy, done, done_id, done_err
    );
endinterface

// File: rtl/latch_wr_sched.sv
// Round-robin write scheduler for a latch bank: setup / enable pulse / hold phases plus serialised clears.
// Define LATCH_SCHED_HOLD_EN for the 4-cycle cadence with a HOLD phase; otherwise done lands in PULSE (3-cycle cadence).
module latch_wr_sched #(
    parameter int NREQ = 4,
    parameter int NENT = 8,
    parameter int DW   = 8,
    // Widen beyond $clog2(NENT) to let out-of-range addresses reach the error path.
    parameter int AW   = $clog2(NENT)
) (
    input  logic            clk,
    input  logic            rst,
    latch_wr_sched_if.slave bus
);
    localparam int IW = $clog2(NREQ);
    localparam logic [AW:0] NENT_W = (AW+1)'(NENT);

    typedef enum logic [2:0] {S_CLR, S_IDLE, S_SETUP, S_PULSE, S_HOLD} state_t;

    state_t          r_state;
    logic [IW-1:0]   r_rr;
    logic [IW-1:0]   r_id;
    logic [AW-1:0]   r_addr;
    logic [NENT-1:0] r_lat_en;
    logic            r_lat_clr;
    logic [DW-1:0]   r_lat_d;
    logic            r_done;
    logic [IW-1:0]   r_done_id;
    logic            r_done_err;
    logic            r_clr_pend;

    logic            w_clr;
    logic            w_gnt_vld;
    logic [IW-1:0]   w_gnt;
    logic [IW-1:0]   w_rr_nxt;
    logic            w_addr_ok;
    logic [NENT-1:0] w_onehot;

    // Scan downward so the requester closest to r_rr is the last one written.
    always_comb begin
        int idx;
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(r_rr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (bus.req_valid[idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = IW'(idx);
            end
        end
    end

    assign w_rr_nxt  = (w_gnt == IW'(NREQ - 1)) ? '0 : w_gnt + 1'b1;
    assign w_clr     = r_clr_pend | bus.clr_req;
    assign w_addr_ok = {1'b0, r_addr} < NENT_W;
    assign w_onehot  = w_addr_ok ? (NENT'(1) << r_addr) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_CLR;
            r_rr       <= '0;
            r_id       <= '0;
            r_addr     <= '0;
            r_lat_en   <= '0;
            r_lat_clr  <= 1'b1;
            r_lat_d    <= '0;
            r_done     <= 1'b0;
            r_done_id  <= '0;
            r_done_err <= 1'b0;
            r_clr_pend <= 1'b0;
        end else begin
            r_lat_en  <= '0;
            r_lat_clr <= 1'b0;
            r_done    <= 1'b0;
            // A clear arriving mid-write waits for the write to finish.
            if (bus.clr_req && r_state != S_IDLE && r_state != S_CLR)
                r_clr_pend <= 1'b1;
            case (r_state)
                S_CLR: begin
                    r_state    <= S_IDLE;
                    r_clr_pend <= 1'b0;
                end
                S_IDLE: begin
                    if (w_clr) begin
                        r_state   <= S_CLR;
                        r_lat_clr <= 1'b1;
                    end else if (w_gnt_vld) begin
                        r_state <= S_SETUP;
                        r_id    <= w_gnt;
                        r_addr  <= bus.req_addr[w_gnt*AW +: AW];
                        r_lat_d <= bus.req_data[w_gnt*DW +: DW];
                        r_rr    <= w_rr_nxt;
                    end
                end
                S_SETUP: begin
                    r_state  <= S_PULSE;
                    r_lat_en <= w_onehot;
`ifndef LATCH_SCHED_HOLD_EN
                    r_done     <= 1'b1;
                    r_done_id  <= r_id;
                    r_done_err <= ~w_addr_ok;
`endif
                end
`ifdef LATCH_SCHED_HOLD_EN
                S_PULSE: begin
                    r_state    <= S_HOLD;
                    r_done     <= 1'b1;
                    r_done_id  <= r_id;
                    r_done_err <= ~w_addr_ok;
                end
                S_HOLD: begin
                    r_state   <= w_clr ? S_CLR : S_IDLE;
                    r_lat_clr <= w_clr;
                end
`else
                S_PULSE: begin
                    r_state   <= w_clr ? S_CLR : S_IDLE;
                    r_lat_clr <= w_clr;
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = (r_state == S_IDLE && !w_clr && w_gnt_vld) ? (NREQ'(1) << w_gnt) : '0;
    assign bus.busy      = (r_state != S_IDLE) | r_clr_pend;
    assign bus.lat_en    = r_lat_en;
    assign bus.lat_clr   = r_lat_clr;
    assign bus.lat_d     = r_lat_d;
    assign bus.done      = r_done;
    assign bus.done_id   = r_done_id;
    assign bus.done_err  = r_done_err;
endmodule
